// File: rtl/ibus_dbus_arbiter_pkg.sv
// Shared types for the naive_mips bus fabric: arbiter states and the
// request bundle also used by the memory and peripheral muxes.
package ibus_dbus_arbiter_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_IBUS = 2'd1,
      ST_DBUS = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] address;
      logic [BE_W-1:0]   byteenable;
      logic              read;
      logic              write;
      logic [DATA_W-1:0] wrdata;
   } bus_req_t;

endpackage

// File: rtl/ibus_dbus_arbiter.sv
// Shares one multi-cycle ack-handshake memory port between the instruction
// and data buses. Data bus has priority, bounded by a starvation counter.
module ibus_dbus_arbiter
   import ibus_dbus_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_WIDTH    = 4
) (
   input  logic              clk,
   input  logic              rst,

   input  logic [ADDR_W-1:0] ibus_address,
   input  logic [BE_W-1:0]   ibus_byteenable,
   input  logic              ibus_read,
   output logic [DATA_W-1:0] ibus_rddata,
   output logic              ibus_stall,

   input  logic [ADDR_W-1:0] dbus_address,
   input  logic [BE_W-1:0]   dbus_byteenable,
   input  logic              dbus_read,
   input  logic              dbus_write,
   input  logic [DATA_W-1:0] dbus_wrdata,
   output logic [DATA_W-1:0] dbus_rddata,
   output logic              dbus_stall,

   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_wrdata,
   input  logic [DATA_W-1:0] mem_rddata,
   input  logic              mem_ack
);

   localparam logic [CNT_WIDTH-1:0] LIMIT   = CNT_WIDTH'(STARVE_LIMIT);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   arb_state_e           state_reg;
   bus_req_t             mem_req_reg;
   logic [CNT_WIDTH-1:0] starve_cnt_reg;

   logic dbus_req;
   logic dbus_wins;

   assign dbus_req  = dbus_read | dbus_write;
   // ibus only overtakes once it has watched STARVE_LIMIT dbus grants go by.
   assign dbus_wins = dbus_req & ((starve_cnt_reg < LIMIT) | ~ibus_read);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         mem_req_reg    <= '0;
         starve_cnt_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (dbus_wins) begin
                  state_reg   <= ST_DBUS;
                  // A simultaneous read+write is illegal; the write wins.
                  mem_req_reg <= '{address:    dbus_address,
                                   byteenable: dbus_byteenable,
                                   read:       ~dbus_write,
                                   write:      dbus_write,
                                   wrdata:     dbus_wrdata};
                  if (ibus_read && starve_cnt_reg != CNT_MAX)
                     starve_cnt_reg <= starve_cnt_reg + 1'b1;
               end else if (ibus_read) begin
                  state_reg      <= ST_IBUS;
                  mem_req_reg    <= '{address:    ibus_address,
                                      byteenable: ibus_byteenable,
                                      read:       1'b1,
                                      write:      1'b0,
                                      wrdata:     '0};
                  starve_cnt_reg <= '0;
               end
            end
            ST_IBUS, ST_DBUS: begin
               // Runs to completion even if the requester has flushed.
               if (mem_ack) begin
                  state_reg         <= ST_IDLE;
                  mem_req_reg.read  <= 1'b0;
                  mem_req_reg.write <= 1'b0;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign mem_address    = mem_req_reg.address;
   assign mem_byteenable = mem_req_reg.byteenable;
   assign mem_read       = mem_req_reg.read;
   assign mem_write      = mem_req_reg.write;
   assign mem_wrdata     = mem_req_reg.wrdata;

   assign ibus_stall = ibus_read & ~((state_reg == ST_IBUS) & mem_ack);
   assign dbus_stall = dbus_req  & ~((state_reg == ST_DBUS) & mem_ack);

   assign ibus_rddata = mem_rddata;
   assign dbus_rddata = mem_rddata;

endmodule
